// File: rtl/pipe_run_ctrl_if.sv
// rtl/pipe_run_ctrl_if.sv - debug command, hazard and stage-control bundle for pipe_run_ctrl
interface pipe_run_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              run_i;
  logic              halt_i;
  logic              step_i;
  logic              burst_i;
  logic [CNT_W-1:0]  burst_len_i;
  logic              bp_en_i;
  logic [ADDR_W-1:0] bp_addr_i;
  logic [ADDR_W-1:0] pc_i;
  logic              stallreq_id_i;
  logic              stallreq_ex_i;
  logic [4:0]        stall_o;
  logic              flush_id_ex_o;
  logic              flush_ex_mem_o;
  logic [1:0]        state_o;
  logic              bp_hit_o;
  logic [CNT_W-1:0]  cycle_cnt_o;

  // Board/datapath side: drives commands and hazards, observes controls
  modport master (
    output run_i, halt_i, step_i, burst_i, burst_len_i, bp_en_i, bp_addr_i,
           pc_i, stallreq_id_i, stallreq_ex_i,
    input  stall_o, flush_id_ex_o, flush_ex_mem_o, state_o, bp_hit_o, cycle_cnt_o
  );

  // Sequencer side
  modport slave (
    input  run_i, halt_i, step_i, burst_i, burst_len_i, bp_en_i, bp_addr_i,
           pc_i, stallreq_id_i, stallreq_ex_i,
    output stall_o, flush_id_ex_o, flush_ex_mem_o, state_o, bp_hit_o, cycle_cnt_o
  );
endinterface

// File: rtl/pipe_run_ctrl.sv
// rtl/pipe_run_ctrl.sv - run/halt/step/burst sequencer producing per-stage hold and bubble controls
module pipe_run_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  pipe_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             resume_q, resume_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             bp_match;
  logic             bp_stop;
  logic             advance;
  logic [4:0]       stall;
  logic             flush_id_ex;
  logic             flush_ex_mem;

  // Same-cycle stage controls: frozen unless this is an advance cycle, then hazard priority EX > ID
  always_comb begin
    bp_match     = bus.bp_en_i && (bus.pc_i == bus.bp_addr_i) && !resume_q;
    // Breakpoints are only honoured while free-running or bursting, never while single-stepping
    bp_stop      = ((state_q == ST_RUN) || (state_q == ST_BURST)) && bp_match;
    advance      = (state_q != ST_HALT) && !bp_stop;
    stall        = 5'b11111;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    if (advance) begin
      if (bus.stallreq_ex_i) begin
        stall        = 5'b00111;
        flush_ex_mem = 1'b1;
      end else if (bus.stallreq_id_i) begin
        stall       = 5'b00011;
        flush_id_ex = 1'b1;
      end else begin
        stall = 5'b00000;
      end
    end
  end

  // Next-state logic for the run-control FSM, cycle counter, burst counter and flags
  always_comb begin
    state_d     = state_q;
    resume_d    = resume_q;
    bp_hit_d    = bp_hit_q;
    cycle_cnt_d = cycle_cnt_q;
    burst_cnt_d = burst_cnt_q;

    // Hazard cycles still count: the pipeline clock-enable logic is live, only stages hold
    if (advance) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      resume_d    = 1'b0;
    end

    case (state_q)
      ST_HALT: begin
        if (bus.halt_i) begin
          state_d = ST_HALT;
        end else if (bus.run_i) begin
          state_d  = ST_RUN;
          resume_d = 1'b1;
          bp_hit_d = 1'b0;
        end else if (bus.burst_i && (bus.burst_len_i != '0)) begin
          state_d     = ST_BURST;
          burst_cnt_d = bus.burst_len_i;
          resume_d    = 1'b1;
          bp_hit_d    = 1'b0;
        end else if (bus.step_i) begin
          state_d  = ST_STEP;
          resume_d = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (bp_stop) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else if (bus.halt_i) begin
          state_d = ST_HALT;
        end
      end
      ST_BURST: begin
        if (bp_stop) begin
          // Frozen cycle: the remaining burst length is kept as-is
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else begin
          burst_cnt_d = burst_cnt_q - CNT_W'(1);
          if (bus.halt_i) begin
            state_d = ST_HALT;
          end else if (bus.run_i) begin
            state_d     = ST_RUN;
            burst_cnt_d = '0;
          end else if (burst_cnt_q == CNT_W'(1)) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_STEP: begin
        // Exactly one advance cycle regardless of any command seen meanwhile
        state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // State and counter registers; reset forces a halted, cleared sequencer immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HALT;
      resume_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
      cycle_cnt_q <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      bp_hit_q    <= bp_hit_d;
      cycle_cnt_q <= cycle_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.flush_id_ex_o  = flush_id_ex;
  assign bus.flush_ex_mem_o = flush_ex_mem;
  assign bus.state_o        = state_q;
  assign bus.bp_hit_o       = bp_hit_q;
  assign bus.cycle_cnt_o    = cycle_cnt_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb/tb_pipe_run_ctrl.sv - table-driven scoreboard bench for pipe_run_ctrl
module tb_pipe_run_ctrl;

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_RUN   = 4'b1000;
  localparam logic [3:0] C_HALT  = 4'b0100;
  localparam logic [3:0] C_STEP  = 4'b0010;
  localparam logic [3:0] C_BURST = 4'b0001;

  typedef struct packed {
    logic [3:0]  cmd;      // {run, halt, step, burst}
    logic [15:0] len;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [1:0]  hz;       // {stallreq_ex, stallreq_id}
    logic [4:0]  e_stall;
    logic [1:0]  e_fl;     // {flush_ex_mem, flush_id_ex}
    logic [1:0]  e_state;
    logic [15:0] e_cnt;
    logic        e_bp;
    logic [15:0] e_pc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] pc_model;
  int          errors;
  int          checks;
  vec_t        tbl[$];
  vec_t        sb[$];

  pipe_run_ctrl_if #(.ADDR_W(16), .CNT_W(16)) ifc ();

  pipe_run_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple PC stage: advances whenever its hold bit is low
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_model <= 16'h0000;
    else if (!ifc.stall_o[0]) pc_model <= pc_model + 16'h0001;
  end
  assign ifc.pc_i = pc_model;

  function automatic vec_t mk(input logic [3:0] cmd, input logic [15:0] len, input logic bp_en,
                              input logic [15:0] bp_addr, input logic [1:0] hz, input logic [4:0] st,
                              input logic [1:0] fl, input logic [1:0] state, input logic [15:0] cnt,
                              input logic bp, input logic [15:0] pc);
    vec_t v;
    v.cmd = cmd; v.len = len; v.bp_en = bp_en; v.bp_addr = bp_addr; v.hz = hz;
    v.e_stall = st; v.e_fl = fl; v.e_state = state; v.e_cnt = cnt; v.e_bp = bp; v.e_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    ifc.run_i = 1'b0; ifc.halt_i = 1'b0; ifc.step_i = 1'b0; ifc.burst_i = 1'b0;
    ifc.burst_len_i = 16'h0; ifc.bp_en_i = 1'b0; ifc.bp_addr_i = 16'h0;
    ifc.stallreq_id_i = 1'b0; ifc.stallreq_ex_i = 1'b0;
  endtask

  // One cycle: drive after the edge, queue expectation, compare at the falling edge
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    {ifc.run_i, ifc.halt_i, ifc.step_i, ifc.burst_i} = v.cmd;
    ifc.burst_len_i = v.len;
    ifc.bp_en_i = v.bp_en;
    ifc.bp_addr_i = v.bp_addr;
    {ifc.stallreq_ex_i, ifc.stallreq_id_i} = v.hz;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk("stall", {11'h0, ifc.stall_o}, {11'h0, e.e_stall});
    chk("flush", {14'h0, ifc.flush_ex_mem_o, ifc.flush_id_ex_o}, {14'h0, e.e_fl});
    chk("state", {14'h0, ifc.state_o}, {14'h0, e.e_state});
    chk("cycle_cnt", ifc.cycle_cnt_o, e.e_cnt);
    chk("bp_hit", {15'h0, ifc.bp_hit_o}, {15'h0, e.e_bp});
    chk("pc", pc_model, e.e_pc);
  endtask

  task automatic reset_check(input string name);
    chk({name, "_stall"}, {11'h0, ifc.stall_o}, 16'h001f);
    chk({name, "_state"}, {14'h0, ifc.state_o}, 16'h0000);
    chk({name, "_cnt"}, ifc.cycle_cnt_o, 16'h0000);
    chk({name, "_flush"}, {14'h0, ifc.flush_ex_mem_o, ifc.flush_id_ex_o}, 16'h0000);
    chk({name, "_bp"}, {15'h0, ifc.bp_hit_o}, 16'h0000);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_check("reset");
    rst = 1'b1;

    // cmd, len, bp_en, bp_addr, hz, stall, flush, state, cnt, bp, pc
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd0, 0, 16'd0));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd0, 0, 16'd0));
    tbl.push_back(mk(C_STEP,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd0, 0, 16'd0));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd2, 16'd0, 0, 16'd0));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd1, 0, 16'd1));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd1, 0, 16'd1));
    // burst of 4 with an ID hazard on its second cycle
    tbl.push_back(mk(C_BURST, 16'd4, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd1, 0, 16'd1));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd3, 16'd1, 0, 16'd1));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b01, 5'h03, 2'b01, 2'd3, 16'd2, 0, 16'd2));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd3, 16'd3, 0, 16'd2));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd3, 16'd4, 0, 16'd3));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd5, 0, 16'd4));
    // run: EX beats ID, then halt lets the current cycle advance
    tbl.push_back(mk(C_RUN,   16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd5, 0, 16'd4));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b11, 5'h07, 2'b10, 2'd1, 16'd5, 0, 16'd4));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b10, 5'h07, 2'b10, 2'd1, 16'd6, 0, 16'd4));
    tbl.push_back(mk(C_HALT,  16'd0, 0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd1, 16'd7, 0, 16'd4));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd8, 0, 16'd5));
    // zero-length burst is ignored
    tbl.push_back(mk(C_BURST, 16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd8, 0, 16'd5));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd8, 0, 16'd5));
    // step ignores breakpoint and completes despite halt
    tbl.push_back(mk(C_STEP,  16'd0, 1, 16'h5, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd8, 0, 16'd5));
    tbl.push_back(mk(C_HALT,  16'd0, 1, 16'h5, 2'b00, 5'h00, 2'b00, 2'd2, 16'd8, 0, 16'd5));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd9, 0, 16'd6));
    // halt outranks run while halted
    tbl.push_back(mk(C_HALT | C_RUN, 16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd9, 0, 16'd6));
    tbl.push_back(mk(C_NONE,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd9, 0, 16'd6));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset in the middle of a run takes effect without a clock edge
    apply(mk(C_RUN,  16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd9,  0, 16'd6));
    apply(mk(C_NONE, 16'd0, 0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd1, 16'd9,  0, 16'd6));
    apply(mk(C_NONE, 16'd0, 0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd1, 16'd10, 0, 16'd7));
    #2;
    rst = 1'b0;
    #1;
    reset_check("midrun_reset");
    chk("midrun_reset_pc", pc_model, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Breakpoint at 0x0005, then resume past it
    apply(mk(C_RUN, 16'd0, 1, 16'h5, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd0, 0, 16'd0));
    for (int k = 0; k < 5; k++)
      apply(mk(C_NONE, 16'd0, 1, 16'h5, 2'b00, 5'h00, 2'b00, 2'd1, 16'(k), 0, 16'(k)));
    apply(mk(C_NONE, 16'd0, 1, 16'h5, 2'b00, 5'h1f, 2'b00, 2'd1, 16'd5, 0, 16'd5));
    apply(mk(C_NONE, 16'd0, 1, 16'h5, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd5, 1, 16'd5));
    apply(mk(C_RUN,  16'd0, 1, 16'h5, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd5, 1, 16'd5));
    apply(mk(C_NONE, 16'd0, 1, 16'h5, 2'b00, 5'h00, 2'b00, 2'd1, 16'd5, 0, 16'd5));
    apply(mk(C_HALT, 16'd0, 1, 16'h5, 2'b00, 5'h00, 2'b00, 2'd1, 16'd6, 0, 16'd6));
    apply(mk(C_NONE, 16'd0, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd7, 0, 16'd7));

    // Burst of 10 cut short by halt on its third cycle
    apply(mk(C_BURST, 16'd10, 0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd7,  0, 16'd7));
    apply(mk(C_NONE,  16'd0,  0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd3, 16'd7,  0, 16'd7));
    apply(mk(C_NONE,  16'd0,  0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd3, 16'd8,  0, 16'd8));
    apply(mk(C_HALT,  16'd0,  0, 16'h0, 2'b00, 5'h00, 2'b00, 2'd3, 16'd9,  0, 16'd9));
    apply(mk(C_NONE,  16'd0,  0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd10, 0, 16'd10));
    apply(mk(C_NONE,  16'd0,  0, 16'h0, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd10, 0, 16'd10));

    // Halt coinciding with a breakpoint hit: frozen, bp_hit set
    apply(mk(C_RUN,  16'd0, 1, 16'd11, 2'b00, 5'h1f, 2'b00, 2'd0, 16'd10, 0, 16'd10));
    apply(mk(C_NONE, 16'd0, 1, 16'd11, 2'b00, 5'h00, 2'b00, 2'd1, 16'd10, 0, 16'd10));
    apply(mk(C_HALT, 16'd0, 1, 16'd11, 2'b00, 5'h1f, 2'b00, 2'd1, 16'd11, 0, 16'd11));
    apply(mk(C_NONE, 16'd0, 0, 16'd0,  2'b00, 5'h1f, 2'b00, 2'd0, 16'd11, 1, 16'd11));

    chk("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
Run-control and stall sequencer for the 5-stage Naive CPU pipeline (PC -> IF/ID -> ID/EX -> EX/MEM -> MEM/WB). Converts board-level debug commands (run, halt, single-step, N-cycle burst, PC breakpoint) and datapath hazard requests from ID/EX into per-stage hold and bubble controls. Sits beside the observer so a halted pipeline can be inspected stage by stage.

Parameters:
ADDR_W, 16, width of PC / breakpoint address (matches InstAddrBus)
CNT_W, 16, width of burst length and cycle counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
run_i  in  1  pulse: enter free-running mode
halt_i  in  1  pulse: stop at next edge
step_i  in  1  pulse: advance exactly one cycle
burst_i  in  1  pulse: advance burst_len_i cycles
burst_len_i  in  CNT_W  burst length, sampled with burst_i
bp_en_i  in  1  breakpoint enable
bp_addr_i  in  ADDR_W  breakpoint PC
pc_i  in  ADDR_W  current PC from if_pc
stallreq_id_i  in  1  ID hazard (load-use), hold front end
stallreq_ex_i  in  1  EX multi-cycle busy
stall_o  out  5  hold bits: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
flush_id_ex_o  out  1  load bubble (NOP, wreg=0) into ID/EX
flush_ex_mem_o  out  1  load bubble into EX/MEM
state_o  out  2  00 HALT, 01 RUN, 10 STEP, 11 BURST
bp_hit_o  out  1  sticky: last halt caused by breakpoint
cycle_cnt_o  out  CNT_W  count of advance cycles

Behaviour:
- Reset (rst=0, async): state HALT, stall_o=5'b11111, flushes 0, bp_hit_o 0, cycle_cnt_o 0, burst counter 0, resume flag 0. Outputs take these values immediately while rst=0.
- State register changes on rising clk only. stall_o and flushes are combinational from state, resume flag, pc_i, breakpoint inputs and stall requests (same-cycle response).
- Frozen cycle: stall_o=11111, flushes 0, cycle_cnt unchanged. This covers state HALT and a breakpoint-hit cycle.
- Advance cycle: any non-frozen cycle in RUN, STEP or BURST; cycle_cnt_o+1 at the edge, wrapping at 2^CNT_W.
- Hazard priority on an advance cycle:
  - stallreq_ex_i=1: stall_o=00111, flush_ex_mem_o=1.
  - Else stallreq_id_i=1: stall_o=00011, flush_id_ex_o=1.
  - Else stall_o=00000.
  - Hazard cycles still count as advance cycles and as a step/burst cycle.
- HALT transitions, priority halt_i > run_i > burst_i > step_i:
  - run_i -> RUN.
  - burst_i with burst_len_i != 0 -> BURST, counter <= burst_len_i. burst_len_i=0 is ignored; stay HALT.
  - step_i -> STEP.
  - Leaving HALT sets resume flag and clears bp_hit_o.
- STEP: exactly one advance cycle, then -> HALT. Commands during STEP are ignored, except halt_i, which still lets this single cycle complete.
- BURST: counter-1 each advance cycle; counter==1 in a cycle -> HALT at that edge.
- halt_i in RUN/BURST: the current cycle still advances; -> HALT at the edge.
- run_i in BURST -> RUN (counter dropped). Other commands in RUN/BURST are ignored.
- Breakpoint applies in RUN/BURST only, never in STEP.
  - Hit condition: bp_en_i && pc_i==bp_addr_i && resume flag==0.
  - On hit, the cycle is frozen; -> HALT; bp_hit_o <= 1; burst counter is not decremented.
- Resume flag clears after the first advance cycle, so resuming from a breakpoint PC moves past it.
- Simultaneous halt_i with a breakpoint hit: frozen cycle, bp_hit_o=1.
- Reset mid-burst or mid-run aborts to HALT with all reset values.

Test Plan:
- Reset: rst=0 for 3 cycles, then 1 -> state_o=00, stall_o=11111, cycle_cnt_o=0, flushes 0; PC stays constant.
- Single step: step_i pulse -> exactly one cycle with stall_o=00000, cycle_cnt_o=1, state back to 00; PC advances once.
- Burst with hazard: burst_len_i=4 plus burst_i, stallreq_id_i=1 on 2nd cycle -> 4 advance cycles; 2nd has stall_o=00011 and flush_id_ex_o=1; then HALT, cycle_cnt_o=4.
- Hazard priority: in RUN, stallreq_id_i=1 and stallreq_ex_i=1 together -> stall_o=00111, flush_ex_mem_o=1, flush_id_ex_o=0.
- Breakpoint: bp_addr_i=0x0005, bp_en_i=1, run_i -> freezes with pc_i=0x0005, state 00, bp_hit_o=1. run_i again -> PC passes 0x0005 without re-halting and bp_hit_o=0.
- Halt and reset races:
  - burst_len_i=10, halt_i on 3rd cycle -> HALT after 3 advance cycles.
  - Separately, rst=0 mid-RUN -> immediate stall_o=11111, cycle_cnt_o=0.
  - Separately, burst_len_i=0 -> stays HALT.
